tick_monitor: RTL and testbench
===============================

Name: tick_monitor

Overview:
- Consumer-side checker for the periodic one-cycle tick produced by the design's seconds timer.
- Measures the clk-cycle interval between successive tick pulses and flags early and missing ticks.
- Declares lock after a run of in-tolerance intervals.
- Keeps a wrapping count of good seconds for downstream display and debug logic.

Parameters:
- PERIOD, 50_000_001: expected interval in clk cycles between tick rising edges. The timer's count runs 0..FREQ, so the interval is FREQ+1.
- TOL, 1000: accepted deviation in cycles, either side of PERIOD. Must satisfy TOL < PERIOD.
- CW, 26: interval counter width. Must satisfy 2^CW > PERIOD+TOL+1.
- LOCK_CNT, 3: consecutive good intervals required to assert locked (1..15).
- SEC_W, 16: width of the good-second counter.

Ports:
- clk, input, 1: single system clock; all logic is on posedge clk.
- reset, input, 1: asynchronous, active-low reset. Asserting it (low) clears all state immediately; release is synchronous to clk.
- tick_in, input, 1: tick from the timer, same clock domain, no synchroniser.
- clr, input, 1: synchronous clear of the sticky error flags.
- meas_period, output, CW: most recent measured interval.
- meas_valid, output, 1: one-cycle pulse when meas_period updates.
- locked, output, 1: high after LOCK_CNT consecutive good intervals.
- err_early, output, 1: sticky; an interval < PERIOD-TOL was seen.
- err_missing, output, 1: sticky; no tick within PERIOD+TOL cycles.
- sec_count, output, SEC_W: count of good intervals, wraps to 0.

Behaviour:
- Reset (reset low): state=WAIT_FIRST; cnt, tick_q, good_run and all outputs = 0.
- Edge detect: edge = tick_in & ~tick_q, with tick_q registered each cycle.
  - A tick held high counts once.
  - tick_in high at reset release produces an edge on the first clock.
- WAIT_FIRST: cnt held at 0. On edge: go to MEASURE, cnt<=1. No meas_valid and no checks on this first edge.
- MEASURE, no edge: cnt<=cnt+1.
- MEASURE, edge: interval = current cnt, so edges P cycles apart give cnt=P.
  - meas_period<=cnt and meas_valid<=1, registered one cycle after the edge cycle.
  - cnt<=1 and the state stays MEASURE.
- Good interval, PERIOD-TOL <= cnt <= PERIOD+TOL:
  - sec_count<=sec_count+1, wrapping modulo 2^SEC_W.
  - good_run increments, saturating at LOCK_CNT.
  - locked<=1 when the incremented good_run equals LOCK_CNT.
- Early interval, cnt < PERIOD-TOL: err_early<=1, good_run<=0, locked<=0; sec_count unchanged.
- Missing tick:
  - Condition: in MEASURE with no edge while cnt==PERIOD+TOL.
  - Action: err_missing<=1, locked<=0, good_run<=0, cnt<=0, state<=WAIT_FIRST.
  - An edge arriving exactly at cnt==PERIOD+TOL is good.
  - An edge one cycle later is handled as a first edge in WAIT_FIRST.
- clr: clears err_early and err_missing on the next clock. If a set condition occurs on the same cycle, set wins and the flag stays 1. clr does not affect locked, good_run, sec_count or the counter.
- Asserting reset mid-measurement discards the partial interval. Counting restarts from WAIT_FIRST after release.
- No arithmetic overflow: cnt never exceeds PERIOD+TOL by construction.

Test Plan (PERIOD=51, TOL=2, LOCK_CNT=3, CW=8, SEC_W=3 unless noted):
1. Five ticks spaced 51 cycles → four meas_valid pulses, each with meas_period=51. locked rises on the clock after tick 4, sec_count=4, both error flags stay 0.
2. Lock first, then give an interval of 48 → err_early=1, locked=0, meas_period=48. Follow with three intervals of 49, 53 and 51 → locked=1 again, err_early still 1.
3. After lock, give an interval of 53 → accepted. Then no tick for 54+ cycles → err_missing=1 and locked=0 at the clock where cnt==53 with no edge. The next tick produces no meas_valid; the tick after it measures normally.
4. With err_early=1, pulse clr → flag is 0 next cycle. Pulse clr in the same cycle as an early edge → err_early stays 1.
5. Eight good intervals → sec_count wraps 7→0.
6. Lower reset mid-interval at cnt=30 → all outputs 0 immediately. Hold tick_in high across the reset release → exactly one edge is detected, and the state moves to MEASURE with no meas_valid.

Source files
------------

// File: rtl/tick_monitor.sv
// tick_monitor: checks spacing of the seconds-timer tick,
// flags early/missing ticks, tracks lock and good seconds.
module tick_monitor #(
  parameter int unsigned PERIOD   = 50_000_001,
  parameter int unsigned TOL      = 1000,
  parameter int unsigned CW       = 26,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned SEC_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             clr,
  output logic [CW-1:0]    meas_period,
  output logic             meas_valid,
  output logic             locked,
  output logic             err_early,
  output logic             err_missing,
  output logic [SEC_W-1:0] sec_count
);

  localparam logic [CW-1:0]    LO   = CW'(PERIOD - TOL);
  localparam logic [CW-1:0]    HI   = CW'(PERIOD + TOL);
  localparam logic [CW-1:0]    C1   = CW'(1);
  localparam logic [SEC_W-1:0] S1   = SEC_W'(1);
  localparam logic [3:0]       LC   = 4'(LOCK_CNT);

  typedef enum logic {
    WAIT_FIRST,
    MEASURE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             tick_q;
  logic [3:0]       run_q, run_d;
  logic [3:0]       run_inc;
  logic [CW-1:0]    mp_q, mp_d;
  logic             mv_q, mv_d;
  logic             lk_q, lk_d;
  logic             ee_q, ee_d;
  logic             em_q, em_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             tick_edge;

  assign tick_edge = tick_in & ~tick_q;
  assign run_inc   = (run_q >= LC) ? LC : run_q + 4'd1;

  // Next-state: interval measurement, lock tracking, sticky errors
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    mp_d    = mp_q;
    mv_d    = 1'b0;
    lk_d    = lk_q;
    ee_d    = ee_q & ~clr;
    em_d    = em_q & ~clr;
    sec_d   = sec_q;
    unique case (state_q)
      WAIT_FIRST: begin
        cnt_d = '0;
        if (tick_edge) begin
          state_d = MEASURE;
          cnt_d   = C1;
        end
      end
      MEASURE: begin
        if (tick_edge) begin
          mp_d  = cnt_q;
          mv_d  = 1'b1;
          cnt_d = C1;
          if (cnt_q < LO) begin
            ee_d  = 1'b1;
            run_d = '0;
            lk_d  = 1'b0;
          end else begin
            sec_d = sec_q + S1;
            run_d = run_inc;
            if (run_inc == LC) lk_d = 1'b1;
          end
        end else if (cnt_q == HI) begin
          em_d    = 1'b1;
          lk_d    = 1'b0;
          run_d   = '0;
          cnt_d   = '0;
          state_d = WAIT_FIRST;
        end else begin
          cnt_d = cnt_q + C1;
        end
      end
      default: begin
        state_d = WAIT_FIRST;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= WAIT_FIRST;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      run_q   <= '0;
      mp_q    <= '0;
      mv_q    <= 1'b0;
      lk_q    <= 1'b0;
      ee_q    <= 1'b0;
      em_q    <= 1'b0;
      sec_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_in;
      run_q   <= run_d;
      mp_q    <= mp_d;
      mv_q    <= mv_d;
      lk_q    <= lk_d;
      ee_q    <= ee_d;
      em_q    <= em_d;
      sec_q   <= sec_d;
    end
  end

  assign meas_period = mp_q;
  assign meas_valid  = mv_q;
  assign locked      = lk_q;
  assign err_early   = ee_q;
  assign err_missing = em_q;
  assign sec_count   = sec_q;

endmodule

// File: tb/tb_tick_monitor.sv
// tb_tick_monitor: randomized tick spacing against an
// edge-timestamp reference model with a measurement scoreboard.
module tb_tick_monitor;

  localparam int P  = 51;
  localparam int T  = 2;
  localparam int L  = 3;
  localparam int CW = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tick_in = 1'b0;
  logic          clr = 1'b0;
  logic [CW-1:0] meas_period;
  logic          meas_valid;
  logic          locked;
  logic          err_early;
  logic          err_missing;
  logic [SW-1:0] sec_count;

  tick_monitor #(
    .PERIOD(P), .TOL(T), .CW(CW), .LOCK_CNT(L), .SEC_W(SW)
  ) dut (
    .clk(clk), .reset(reset), .tick_in(tick_in), .clr(clr),
    .meas_period(meas_period), .meas_valid(meas_valid),
    .locked(locked), .err_early(err_early),
    .err_missing(err_missing), .sec_count(sec_count)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int per;
    bit lk;
    bit ee;
    bit em;
    int sec;
  } exp_t;

  exp_t q[$];

  int nchk = 0;
  int nerr = 0;

  // reference model state: timestamps of tick edges
  int cyc = 0;
  bit prev = 0;
  bit meas = 0;
  int last = 0;
  int run = 0;
  bit m_lk = 0;
  bit m_ee = 0;
  bit m_em = 0;
  int m_sec = 0;
  int m_mp = 0;
  bit m_mv = 0;

  task automatic chk(string nm, logic [31:0] act, int exp);
    nchk++;
    if (act !== 32'(exp)) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    prev = 0; meas = 0; last = 0; run = 0;
    m_lk = 0; m_ee = 0; m_em = 0; m_sec = 0;
    m_mp = 0; m_mv = 0;
    q.delete();
  endtask

  task automatic model_step();
    bit e;
    int k;
    exp_t x;
    cyc++;
    m_mv = 0;
    e = tick_in && !prev;
    prev = tick_in;
    if (clr) begin
      m_ee = 0;
      m_em = 0;
    end
    if (!meas) begin
      if (e) begin
        meas = 1;
        last = cyc;
      end
    end else begin
      k = cyc - last;
      if (e) begin
        if (k < P - T) begin
          m_ee = 1;
          run = 0;
          m_lk = 0;
        end else begin
          m_sec = (m_sec + 1) % (1 << SW);
          run = (run + 1 > L) ? L : run + 1;
          if (run == L) m_lk = 1;
        end
        m_mp = k;
        m_mv = 1;
        last = cyc;
        x.per = k; x.lk = m_lk; x.ee = m_ee;
        x.em = m_em; x.sec = m_sec;
        q.push_back(x);
      end else if (k == P + T) begin
        m_em = 1;
        m_lk = 0;
        run = 0;
        meas = 0;
      end
    end
  endtask

  // model: advances on each sampled clock, clears on reset
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) model_reset();
    else model_step();
  end

  // monitor: status every cycle, scoreboard on meas_valid
  initial forever begin
    exp_t x;
    @(negedge clk);
    chk("meas_valid", meas_valid, m_mv);
    chk("locked", locked, m_lk);
    chk("err_early", err_early, m_ee);
    chk("err_missing", err_missing, m_em);
    chk("sec_count", sec_count, m_sec);
    chk("meas_period", meas_period, m_mp);
    if (meas_valid === 1'b1) begin
      if (q.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL sb_empty: meas_valid with no expected entry at %0t",
                 $time);
      end else begin
        x = q.pop_front();
        chk("sb_period", meas_period, x.per);
        chk("sb_locked", locked, x.lk);
        chk("sb_early", err_early, x.ee);
        chk("sb_missing", err_missing, x.em);
        chk("sb_sec", sec_count, x.sec);
      end
    end
  end

  task automatic drv(bit t, bit c);
    @(negedge clk);
    tick_in = t;
    clr = c;
  endtask

  // one tick edge followed by n-1 more cycles (edge-to-edge = n)
  task automatic iv(int n, int w, int ca);
    for (int i = 0; i < n; i++) drv(i < w, i == ca);
  endtask

  initial begin
    int n, w, ca;
    repeat (3) drv(0, 0);
    @(negedge clk) reset = 1'b1;
    repeat (2) drv(0, 0);
    // nominal spacing, lock
    repeat (5) iv(51, 1, -1);
    // early then recover lock
    iv(48, 1, -1);
    iv(49, 2, -1);
    iv(53, 1, -1);
    iv(51, 1, -1);
    // max interval, then missing tick
    iv(53, 2, -1);
    iv(70, 1, -1);
    iv(51, 1, -1);
    iv(51, 1, -1);
    // clr alone, then clr colliding with an early edge
    iv(51, 1, 10);
    iv(45, 1, -1);
    iv(51, 1, 0);
    iv(51, 1, -1);
    // wrap of sec_count
    repeat (9) iv(51, $urandom_range(1, 3), -1);
    // reset mid-interval with tick held across release
    for (int i = 0; i < 30; i++) drv(i == 0, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick_in = 1'b1;
    #1;
    chk("rst_valid", meas_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_early", err_early, 0);
    chk("rst_missing", err_missing, 0);
    chk("rst_sec", sec_count, 0);
    chk("rst_period", meas_period, 0);
    repeat (3) drv(1, 0);
    @(negedge clk) reset = 1'b1;
    repeat (4) drv(1, 0);
    iv(47, 1, -1);
    repeat (4) iv(51, 1, -1);
    // randomized spacing
    repeat (250) begin
      n = $urandom_range(44, 58);
      if ($urandom_range(0, 19) == 0) n = $urandom_range(54, 70);
      w = $urandom_range(1, 3);
      ca = ($urandom_range(0, 9) == 0) ? $urandom_range(0, n - 1) : -1;
      iv(n, w, ca);
    end
    repeat (3) drv(0, 0);
    chk("sb_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
